// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: captures each completed byte (plus its parity-error tag)
// once per int_rx_finish rising edge and hands bytes to a consumer through a registered read port.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          int_rx_finish,
  input  logic          pari_err,
  input  logic          clr,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_perr,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Storage is deliberately left out of reset so it maps onto block RAM.
  logic [8:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rx_fin_dly_q, rx_fin_dly_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_perr_q, rd_perr_d;

  logic empty_w;
  logic full_w;
  logic wr_req;
  logic rd_req;
  logic wr_do;
  logic rd_do;

  always_comb begin
    empty_w = (count_q == '0);
    full_w  = (count_q == FULL_CNT);
    wr_req  = int_rx_finish & ~rx_fin_dly_q;
    rd_req  = rd_en & ~empty_w;
    // When full, a write only fits if a read frees the slot in the same cycle.
    wr_do   = ~clr & wr_req & (~full_w | rd_req);
    rd_do   = ~clr & rd_req;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    rx_fin_dly_d = int_rx_finish;
    rd_valid_d   = rd_do;
    rd_data_d    = rd_data_q;
    rd_perr_d    = rd_perr_q;

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_do) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_do) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem[rd_ptr_q][7:0];
        rd_perr_d = mem[rd_ptr_q][8];
      end
      case ({wr_do, rd_do})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_req && full_w && !rd_req) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      rx_fin_dly_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 8'h00;
      rd_perr_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      rx_fin_dly_q <= rx_fin_dly_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_perr_q    <= rd_perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do && !rst) begin
      mem[wr_ptr_q] <= {pari_err, rx_data};
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_perr  = rd_perr_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign empty    = empty_w;
  assign full     = full_w;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, edge detection, overflow, full/empty corner
// cases, parity tag, flush and asynchronous reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       int_rx_finish = 1'b0;
  logic       pari_err = 1'b0;
  logic       clr = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int pulses;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .int_rx_finish(int_rx_finish),
    .pari_err(pari_err), .clr(clr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_perr(rd_perr), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic p);
    rx_data = b;
    pari_err = p;
    int_rx_finish = 1'b1;
    tick();
    int_rx_finish = 1'b0;
    tick();
    $display("wr byte=%02h perr=%0d count=%0d", b, p, count);
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] b, input logic p);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    $display("rd byte=%02h perr=%0d valid=%0d", rd_data, rd_perr, rd_valid);
    if (rd_valid) pulses++;
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, b);
    chk({tag, "_perr"}, rd_perr, p);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count, 5'd0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_valid"}, rd_valid, 1'b0);
    chk({tag, "_data"}, rd_data, 8'h00);
    chk({tag, "_perr"}, rd_perr, 1'b0);
  endtask

  logic [7:0] seq [6];

  initial begin
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
    seq[3] = 8'hAA; seq[4] = 8'h12; seq[5] = 8'h34;

    // Reset state, observed while rst is held.
    #2;
    chk_reset_vals("rst0");
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Write-to-readable latency of one cycle.
    rx_data = seq[0];
    pari_err = 1'b0;
    int_rx_finish = 1'b1;
    tick();
    chk("lat_empty", empty, 1'b0);
    chk("lat_count", count, 5'd1);
    int_rx_finish = 1'b0;
    tick();

    // In-order data.
    for (int i = 1; i < 6; i++) wr_byte(seq[i], 1'b0);
    chk("ord_count", count, 5'd6);
    pulses = 0;
    for (int i = 0; i < 6; i++) rd_byte("ord", seq[i], 1'b0);
    chk("ord_pulses", pulses, 6);
    chk("ord_empty", empty, 1'b1);
    tick();
    chk("ord_valid_drop", rd_valid, 1'b0);

    // Read while empty is ignored.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rde_valid", rd_valid, 1'b0);
    chk("rde_data", rd_data, 8'h34);
    chk("rde_count", count, 5'd0);

    // Held level writes once.
    rx_data = 8'hA5;
    int_rx_finish = 1'b1;
    repeat (5) tick();
    int_rx_finish = 1'b0;
    tick();
    chk("hold_count", count, 5'd1);
    rd_byte("hold", 8'hA5, 1'b0);

    // Parity tag.
    wr_byte(8'h3C, 1'b1);
    wr_byte(8'h3D, 1'b0);
    rd_byte("par0", 8'h3C, 1'b1);
    rd_byte("par1", 8'h3D, 1'b0);

    // Overflow: 17th byte dropped.
    for (int i = 0; i < 17; i++) wr_byte(8'h40 + 8'(i), 1'b0);
    chk("ovf_full", full, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_count", count, 5'd16);
    for (int i = 0; i < 16; i++) rd_byte("ovf_rd", 8'h40 + 8'(i), 1'b0);
    chk("ovf_empty", empty, 1'b1);
    chk("ovf_sticky", overflow, 1'b1);

    // Flush with 3 entries and overflow set.
    for (int i = 0; i < 3; i++) wr_byte(8'hE0 + 8'(i), 1'b0);
    chk("clr_pre_count", count, 5'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_count", count, 5'd0);
    chk("clr_empty", empty, 1'b1);
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_data", rd_data, 8'h4F);

    // Full with simultaneous read and write.
    for (int i = 0; i < 16; i++) wr_byte(8'h60 + 8'(i), 1'b0);
    chk("fsim_full", full, 1'b1);
    rx_data = 8'h99;
    int_rx_finish = 1'b1;
    rd_en = 1'b1;
    tick();
    int_rx_finish = 1'b0;
    rd_en = 1'b0;
    chk("fsim_valid", rd_valid, 1'b1);
    chk("fsim_data", rd_data, 8'h60);
    chk("fsim_count", count, 5'd16);
    chk("fsim_ovf", overflow, 1'b0);
    tick();
    for (int i = 1; i < 16; i++) rd_byte("fsim_rd", 8'h60 + 8'(i), 1'b0);
    rd_byte("fsim_last", 8'h99, 1'b0);
    chk("fsim_empty", empty, 1'b1);

    // Empty with simultaneous read and write.
    rx_data = 8'h77;
    int_rx_finish = 1'b1;
    rd_en = 1'b1;
    tick();
    int_rx_finish = 1'b0;
    rd_en = 1'b0;
    chk("esim_count", count, 5'd1);
    chk("esim_valid", rd_valid, 1'b0);
    tick();
    rd_byte("esim_rd", 8'h77, 1'b0);

    // Asynchronous reset mid-write, released with int_rx_finish still high.
    wr_byte(8'h11, 1'b0);
    wr_byte(8'h22, 1'b0);
    rx_data = 8'hC3;
    int_rx_finish = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst1");
    tick();
    rst = 1'b0;
    tick();
    chk("rel_count", count, 5'd1);
    repeat (2) tick();
    int_rx_finish = 1'b0;
    tick();
    chk("rel_count_hold", count, 5'd1);
    rd_byte("rel_rd", 8'hC3, 1'b0);
    chk("rel_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of entries; power of two, 4 to 256.
REQ-002 SHALL have parameter AW, default 4: pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_data, input, 8 bits: byte from the UART receiver; valid while int_rx_finish is high.
REQ-006 SHALL have port int_rx_finish, input, 1 bit: receiver byte-done indication; a pulse or a level held for one or more cycles.
REQ-007 SHALL have port pari_err, input, 1 bit: receiver parity error for the current byte; sampled with rx_data.
REQ-008 SHALL have port clr, input, 1 bit: synchronous flush.
REQ-009 SHALL have port rd_en, input, 1 bit: consumer read request.
REQ-010 SHALL have port rd_data, output, 8 bits: registered read byte.
REQ-011 SHALL have port rd_perr, output, 1 bit: parity-error tag stored with rd_data.
REQ-012 SHALL have port rd_valid, output, 1 bit: one-cycle strobe marking rd_data and rd_perr as new.
REQ-013 SHALL have port empty, output, 1 bit: high when count is 0.
REQ-014 SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-015 SHALL have port count, output, AW+1 bits: current occupancy.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag for a dropped byte.

Function
REQ-017 SHALL register int_rx_finish once and form wr_req = int_rx_finish & ~int_rx_finish_d, so each byte writes once, however long the level is held.
REQ-018 SHALL store a 9-bit entry {pari_err, rx_data} on wr_req at the write pointer, then advance the write pointer modulo DEPTH.
REQ-019 SHALL accept rd_req = rd_en & ~empty; rd_en while empty is ignored, with no state change and no rd_valid.
REQ-020 SHALL, on rd_req, load rd_data and rd_perr from the read-pointer entry at the next rising edge, pulse rd_valid high for exactly that one cycle, and advance the read pointer modulo DEPTH.
REQ-021 SHALL hold rd_data and rd_perr at their last values when no read occurs.
REQ-022 SHALL update count as +1 on write only, -1 on read only, and unchanged on both or neither.
REQ-023 SHALL compute empty and full combinationally from the registered count.
REQ-024 SHALL, when full and wr_req occurs without rd_req, drop the byte, leave pointers and count unchanged, and set overflow.
REQ-025 SHALL, when full with simultaneous wr_req and rd_req, perform both operations; count stays DEPTH and overflow is not set.
REQ-026 SHALL, when empty with simultaneous wr_req and rd_req, accept the write and ignore the read, so count becomes 1 and rd_valid stays low.
REQ-027 SHALL give priority to clr over all other operations.
REQ-028 SHALL, on clr, zero both pointers, count and overflow, and discard any same-cycle wr_req or rd_req.
REQ-029 SHALL leave rd_data and rd_perr unchanged on clr.
REQ-030 SHALL keep overflow high until clr or rst.
REQ-031 SHALL have a write-to-readable latency of 1 cycle: empty falls on the edge after the wr_req cycle.
REQ-032 SHALL have a read latency of 1 cycle, from rd_en sampled to rd_valid high.
REQ-033 SHALL keep storage contents out of reset; only pointers, flags and output registers are reset.

Reset
REQ-034 SHALL, while rst is high, force asynchronously: pointers 0, count 0, empty 1, full 0, overflow 0, rd_valid 0, rd_data 8'h00, rd_perr 0, int_rx_finish_d 0.
REQ-035 SHALL, if rst asserts mid-operation, discard all held bytes; the first write after release lands at entry 0.
REQ-036 SHALL treat int_rx_finish already high at rst release as a new rising edge, writing exactly one entry.

Verification
REQ-037 SHALL cover in-order data: write 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h12, 8'h34, then read 6 times -> same bytes in order, 6 rd_valid pulses, empty=1 at end.
REQ-038 SHALL cover the held level: int_rx_finish high for 5 cycles with rx_data 8'hA5 -> count becomes 1, not 5.
REQ-039 SHALL cover overflow: 17 writes with DEPTH=16 -> full=1, overflow=1, count=16; 16 reads return the first 16 bytes and the 17th is absent.
REQ-040 SHALL cover full with simultaneous read and write: -> count stays 16, overflow stays 0, read returns the oldest byte, and the new byte appears last after wrap-around.
REQ-041 SHALL cover the parity tag: write 8'h3C with pari_err=1, then 8'h3D with pari_err=0 -> reads give rd_perr 1 then 0.
REQ-042 SHALL cover clr and reset: clr with 3 entries and overflow set -> count 0, empty 1, overflow 0, rd_data unchanged; rst pulsed mid-write -> all REQ-034 values, next write read back correctly.
